// File: rtl/decode.sv
// ID stage of a 5-stage MIPS-style pipeline: main control decode, 32x32 register
// file with write-before-read bypass, immediate sign extension and the ID/EX latch.
module decode #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_4,
  input  logic [31:0]       instr,
  input  logic [4:0]        write_reg_MEMWB,
  input  logic [DATA_W-1:0] write_data_WB,
  input  logic              write_en,
  output logic [1:0]        wb_IDEX,
  output logic [2:0]        mem_IDEX,
  output logic [1:0]        aluop_IDEX,
  output logic              alusrc_IDEX,
  output logic              regdst_IDEX,
  output logic [31:0]       pc_4_IDEX,
  output logic [DATA_W-1:0] rs_IDEX,
  output logic [DATA_W-1:0] rt_IDEX,
  output logic [31:0]       signExt_IDEX,
  output logic [4:0]        instr20_16_IDEX,
  output logic [4:0]        instr15_11_IDEX
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  function automatic logic signed [31:0] sign_ext(input logic signed [15:0] imm);
    return 32'(imm);
  endfunction

  logic [5:0] opcode;
  logic [4:0] rs_addr;
  logic [4:0] rt_addr;
  logic [4:0] rd_addr;

  assign opcode  = instr[31:26];
  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];
  assign rd_addr = instr[15:11];

  // Register file: $0 is hardwired to zero, so its storage is never written.
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];

  always_comb begin
    for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
    if (write_en && (write_reg_MEMWB != 5'd0)) regs_d[write_reg_MEMWB] = write_data_WB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  logic              bypass_rs;
  logic              bypass_rt;
  logic [DATA_W-1:0] rs_rd;
  logic [DATA_W-1:0] rt_rd;

  // A write landing this cycle is forwarded so WB->ID needs no extra stall.
  assign bypass_rs = write_en && (write_reg_MEMWB != 5'd0) && (write_reg_MEMWB == rs_addr);
  assign bypass_rt = write_en && (write_reg_MEMWB != 5'd0) && (write_reg_MEMWB == rt_addr);

  always_comb begin
    rs_rd = regs_q[rs_addr];
    rt_rd = regs_q[rt_addr];
    if (rs_addr == 5'd0) rs_rd = '0;
    else if (bypass_rs)  rs_rd = write_data_WB;
    if (rt_addr == 5'd0) rt_rd = '0;
    else if (bypass_rt)  rt_rd = write_data_WB;
  end

  logic [1:0] wb_d;
  logic [2:0] mem_d;
  logic [1:0] aluop_d;
  logic       alusrc_d;
  logic       regdst_d;

  always_comb begin
    wb_d     = 2'b00;
    mem_d    = 3'b000;
    aluop_d  = 2'b00;
    alusrc_d = 1'b0;
    regdst_d = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        wb_d     = 2'b10;
        aluop_d  = 2'b10;
        regdst_d = 1'b1;
      end
      OP_LW: begin
        wb_d     = 2'b11;
        mem_d    = 3'b010;
        alusrc_d = 1'b1;
      end
      OP_SW: begin
        mem_d    = 3'b001;
        alusrc_d = 1'b1;
      end
      OP_BEQ: begin
        mem_d   = 3'b100;
        aluop_d = 2'b01;
      end
      default: ;
    endcase
  end

  logic [31:0] sext_d;
  assign sext_d = sign_ext(instr[15:0]);

  // ID/EX boundary
  logic [1:0]        wb_q;
  logic [2:0]        mem_q;
  logic [1:0]        aluop_q;
  logic              alusrc_q;
  logic              regdst_q;
  logic [31:0]       pc_4_q;
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;
  logic [31:0]       sext_q;
  logic [4:0]        rt_addr_q;
  logic [4:0]        rd_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q      <= '0;
      mem_q     <= '0;
      aluop_q   <= '0;
      alusrc_q  <= 1'b0;
      regdst_q  <= 1'b0;
      pc_4_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      sext_q    <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      wb_q      <= wb_d;
      mem_q     <= mem_d;
      aluop_q   <= aluop_d;
      alusrc_q  <= alusrc_d;
      regdst_q  <= regdst_d;
      pc_4_q    <= pc_4;
      rs_q      <= rs_rd;
      rt_q      <= rt_rd;
      sext_q    <= sext_d;
      rt_addr_q <= rt_addr;
      rd_addr_q <= rd_addr;
    end
  end

  assign wb_IDEX         = wb_q;
  assign mem_IDEX        = mem_q;
  assign aluop_IDEX      = aluop_q;
  assign alusrc_IDEX     = alusrc_q;
  assign regdst_IDEX     = regdst_q;
  assign pc_4_IDEX       = pc_4_q;
  assign rs_IDEX         = rs_q;
  assign rt_IDEX         = rt_q;
  assign signExt_IDEX    = sext_q;
  assign instr20_16_IDEX = rt_addr_q;
  assign instr15_11_IDEX = rd_addr_q;

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for the decode stage: control decode, register file with
// bypass, sign extension, ID/EX latch timing and asynchronous reset.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_4;
  logic [31:0] instr;
  logic [4:0]  write_reg_MEMWB;
  logic [31:0] write_data_WB;
  logic        write_en;
  logic [1:0]  wb_IDEX;
  logic [2:0]  mem_IDEX;
  logic [1:0]  aluop_IDEX;
  logic        alusrc_IDEX;
  logic        regdst_IDEX;
  logic [31:0] pc_4_IDEX;
  logic [31:0] rs_IDEX;
  logic [31:0] rt_IDEX;
  logic [31:0] signExt_IDEX;
  logic [4:0]  instr20_16_IDEX;
  logic [4:0]  instr15_11_IDEX;

  int n_tests = 0;
  int n_fail  = 0;

  decode dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_4            (pc_4),
    .instr           (instr),
    .write_reg_MEMWB (write_reg_MEMWB),
    .write_data_WB   (write_data_WB),
    .write_en        (write_en),
    .wb_IDEX         (wb_IDEX),
    .mem_IDEX        (mem_IDEX),
    .aluop_IDEX      (aluop_IDEX),
    .alusrc_IDEX     (alusrc_IDEX),
    .regdst_IDEX     (regdst_IDEX),
    .pc_4_IDEX       (pc_4_IDEX),
    .rs_IDEX         (rs_IDEX),
    .rt_IDEX         (rt_IDEX),
    .signExt_IDEX    (signExt_IDEX),
    .instr20_16_IDEX (instr20_16_IDEX),
    .instr15_11_IDEX (instr15_11_IDEX)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic [1:0] wb, input logic [2:0] mem,
                            input logic [1:0] aluop, input logic alusrc, input logic regdst);
    check({tag, ".wb"},     32'(wb_IDEX),     32'(wb));
    check({tag, ".mem"},    32'(mem_IDEX),    32'(mem));
    check({tag, ".aluop"},  32'(aluop_IDEX),  32'(aluop));
    check({tag, ".alusrc"}, 32'(alusrc_IDEX), 32'(alusrc));
    check({tag, ".regdst"}, 32'(regdst_IDEX), 32'(regdst));
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    instr           = 32'h8C220004;
    pc_4            = 32'h00000100;
    write_reg_MEMWB = 5'd0;
    write_data_WB   = 32'h0;
    write_en        = 1'b0;

    // Reset with no clock edge yet
    #2;
    check_ctrl("rst", 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    check("rst.pc4",  pc_4_IDEX,    32'h0);
    check("rst.sext", signExt_IDEX, 32'h0);
    check("rst.rs",   rs_IDEX,      32'h0);
    check("rst.rt",   rt_IDEX,      32'h0);
    check("rst.f20",  32'(instr20_16_IDEX), 32'h0);
    tick();
    check("rst_hold.pc4", pc_4_IDEX, 32'h0);
    rst_n = 1'b1;

    // Fill R1 and R2
    instr = 32'h00000000; write_en = 1'b1; write_reg_MEMWB = 5'd1; write_data_WB = 32'h11111111;
    tick();
    write_reg_MEMWB = 5'd2; write_data_WB = 32'h22222222;
    tick();
    write_en = 1'b0; write_reg_MEMWB = 5'd0; write_data_WB = 32'h0;
    instr = 32'h00221820; pc_4 = 32'h00000200;
    tick();
    check_ctrl("add", 2'b10, 3'b000, 2'b10, 1'b0, 1'b1);
    check("add.rs",   rs_IDEX,      32'h11111111);
    check("add.rt",   rt_IDEX,      32'h22222222);
    check("add.f20",  32'(instr20_16_IDEX), 32'h2);
    check("add.f15",  32'(instr15_11_IDEX), 32'h3);
    check("add.sext", signExt_IDEX, 32'h00001820);
    check("add.pc4",  pc_4_IDEX,    32'h00000200);

    instr = 32'h8C220004; pc_4 = 32'h00000204;
    tick();
    check_ctrl("lw", 2'b11, 3'b010, 2'b00, 1'b1, 1'b0);
    check("lw.sext", signExt_IDEX, 32'h00000004);
    check("lw.pc4",  pc_4_IDEX,    32'h00000204);
    check("lw.rs",   rs_IDEX,      32'h11111111);

    instr = 32'hAC22FFFC; pc_4 = 32'h00000208;
    tick();
    check_ctrl("sw", 2'b00, 3'b001, 2'b00, 1'b1, 1'b0);
    check("sw.sext", signExt_IDEX, 32'hFFFFFFFC);

    instr = 32'h1022FFFF; pc_4 = 32'h0000020C;
    tick();
    check_ctrl("beq", 2'b00, 3'b100, 2'b01, 1'b0, 1'b0);
    check("beq.sext", signExt_IDEX, 32'hFFFFFFFF);
    check("beq.rt",   rt_IDEX,      32'h22222222);

    // Same-cycle write to R5 read on both ports
    instr = 32'h00A50000; write_en = 1'b1; write_reg_MEMWB = 5'd5; write_data_WB = 32'hDEADBEEF;
    tick();
    check("byp.rs", rs_IDEX, 32'hDEADBEEF);
    check("byp.rt", rt_IDEX, 32'hDEADBEEF);
    write_en = 1'b0; write_reg_MEMWB = 5'd0; write_data_WB = 32'h0;
    tick();
    check("r5.rs", rs_IDEX, 32'hDEADBEEF);

    // Writes to $0 never show up
    instr = 32'h00000000; write_en = 1'b1; write_reg_MEMWB = 5'd0; write_data_WB = 32'hFFFFFFFF;
    tick();
    check("r0byp.rs", rs_IDEX, 32'h0);
    write_en = 1'b0; write_data_WB = 32'h0;
    tick();
    check("r0.rs", rs_IDEX, 32'h0);
    check("r0.rt", rt_IDEX, 32'h0);

    instr = 32'hFC000000;
    tick();
    check_ctrl("nop", 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);

    // Reset mid-operation, with a pending write that must be dropped
    instr = 32'h8C220004; pc_4 = 32'h00000300;
    tick();
    check("pre.wb", 32'(wb_IDEX), 32'h3);
    write_en = 1'b1; write_reg_MEMWB = 5'd1; write_data_WB = 32'h99999999;
    rst_n = 1'b0;
    #1;
    check_ctrl("arst", 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    check("arst.pc4",  pc_4_IDEX,    32'h0);
    check("arst.sext", signExt_IDEX, 32'h0);
    check("arst.rs",   rs_IDEX,      32'h0);
    tick();
    rst_n = 1'b1; write_en = 1'b0; write_reg_MEMWB = 5'd0; write_data_WB = 32'h0;
    instr = 32'h00221820; pc_4 = 32'h00000400;
    tick();
    check_ctrl("post", 2'b10, 3'b000, 2'b10, 1'b0, 1'b1);
    check("post.rs",  rs_IDEX,   32'h0);
    check("post.rt",  rt_IDEX,   32'h0);
    check("post.pc4", pc_4_IDEX, 32'h00000400);
    instr = 32'h00A50000;
    tick();
    check("post.r5", rs_IDEX, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port pc_4, input, 32 bits: PC+4 of the instruction in decode.
REQ-004 The block SHALL have port instr, input, 32 bits: instruction in decode.
REQ-005 The block SHALL have port write_reg_MEMWB, input, 5 bits: register-file write address from MEM/WB.
REQ-006 The block SHALL have port write_data_WB, input, 32 bits: register-file write data.
REQ-007 The block SHALL have port write_en, input, 1 bit: register-file write enable.
REQ-008 The block SHALL have port wb_IDEX, output, 2 bits: {regwrite, memtoreg}.
REQ-009 The block SHALL have port mem_IDEX, output, 3 bits: {branch, memread, memwrite}.
REQ-010 The block SHALL have port aluop_IDEX, output, 2 bits: ALU operation class.
REQ-011 The block SHALL have ports alusrc_IDEX and regdst_IDEX, outputs, 1 bit each: ALU B-source select and destination-register select.
REQ-012 The block SHALL have port pc_4_IDEX, output, 32 bits: latched pc_4.
REQ-013 The block SHALL have ports rs_IDEX and rt_IDEX, outputs, 32 bits each: latched register read data for instr[25:21] and instr[20:16].
REQ-014 The block SHALL have port signExt_IDEX, output, 32 bits: latched sign-extended instr[15:0].
REQ-015 The block SHALL have ports instr20_16_IDEX and instr15_11_IDEX, outputs, 5 bits each: latched instr[20:16] and instr[15:11].

Function
REQ-016 All *_IDEX outputs SHALL be registers (ID/EX pipeline latch) loaded on every rising clk edge from the current decode of instr/pc_4; latency is exactly 1 cycle, with no stall or flush input.
REQ-017 Control decode SHALL use opcode instr[31:26] and produce the fields in the order regwrite,memtoreg / branch,memread,memwrite / aluop / alusrc / regdst, as follows:
  - R-type 0x00: wb=10, mem=000, aluop=10, alusrc=0, regdst=1
  - lw 0x23: wb=11, mem=010, aluop=00, alusrc=1, regdst=0
  - sw 0x2B: wb=00, mem=001, aluop=00, alusrc=1, regdst=0
  - beq 0x04: wb=00, mem=100, aluop=01, alusrc=0, regdst=0
  - any other opcode: all control bits 0 (NOP)
REQ-018 Sign extension SHALL be {16{instr[15]}, instr[15:0]}.
REQ-019 The register file SHALL be 32 x 32 bits with two combinational read ports (addresses instr[25:21] and instr[20:16]) and one write port.
REQ-020 The register file SHALL write write_data_WB to write_reg_MEMWB on the rising clk edge when write_en=1.
REQ-021 Register 0 SHALL always read 0, and writes to register 0 SHALL be ignored.
REQ-022 A read address equal to a nonzero write_reg_MEMWB while write_en=1 SHALL return write_data_WB (write-before-read bypass), so a value written in the same cycle is latched into rs_IDEX/rt_IDEX.
REQ-023 Simultaneous bypass on both read ports SHALL be supported.

Reset
REQ-024 While rst_n=0, all *_IDEX outputs SHALL be 0 and all 32 registers SHALL be 0, asynchronously (without waiting for a clock edge).
REQ-025 After rst_n rises, the first rising clk edge SHALL latch normally.
REQ-026 Reset asserted mid-operation SHALL immediately clear the outputs and registers; any write requested in that cycle SHALL be lost.

Verification
REQ-027 Reset scenario: assert rst_n=0 with instr=0x8C220004 and no clock edge -> all outputs 0.
REQ-028 Write-then-read scenario: write R1=0x11111111 and R2=0x22222222, then instr=0x00221820 (add $3,$1,$2) -> wb=10, mem=000, aluop=10, alusrc=0, regdst=1, rs=0x11111111, rt=0x22222222, instr20_16=00010, instr15_11=00011, signExt=0x00001820.
REQ-029 lw scenario: instr=0x8C220004 -> wb=11, mem=010, aluop=00, alusrc=1, regdst=0, signExt=0x00000004; pc_4_IDEX equals pc_4 from the prior cycle.
REQ-030 sw/beq scenario: instr=0xAC22FFFC -> mem=001, signExt=0xFFFFFFFC; then instr=0x1022FFFF -> mem=100, aluop=01, signExt=0xFFFFFFFF.
REQ-031 Bypass and $0 scenario: write_en=1, write_reg=5, data=0xDEADBEEF, instr reads rs=5 in the same cycle -> rs_IDEX=0xDEADBEEF; a write to R0 followed by a read of R0 -> 0.
REQ-032 Unknown-opcode scenario: instr=0xFC000000 -> all control outputs 0.
